// File: rtl/cgra_config_pkg.sv
// ---------------------------------------------------------------------------
// cgra_config_pkg
// Shared bus widths and types for the CGRA memory responder.
//   DATA_BUS_ADD_WIDTH  : byte-address width of every requester port
//   DATA_BUS_DATA_WIDTH : data width of every requester port
//   resp_entry_t        : one latency-pipeline slot (valid, port index, data)
//   idx_width()         : index width for n items, never below 1 bit
// ---------------------------------------------------------------------------
package cgra_config_pkg;

   localparam int DATA_BUS_ADD_WIDTH  = 32;
   localparam int DATA_BUS_DATA_WIDTH = 32;
   localparam int BE_WIDTH            = DATA_BUS_DATA_WIDTH / 8;

   // Wide enough for up to 16 requester ports.
   localparam int PORT_IDX_W = 4;

   typedef struct packed {
      logic                           valid;
      logic [PORT_IDX_W-1:0]          port;
      logic [DATA_BUS_DATA_WIDTH-1:0] data;
   } resp_entry_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cgra_mem_responder_if.sv
// ---------------------------------------------------------------------------
// cgra_mem_responder_if
// Bundle of the NPORTS requester buses seen by the memory responder.
//   slave_data_req_i/we_i/be_i/addr_i/wdata_i : requester -> responder
//   slave_data_gnt_o/rvalid_o/rdata_o         : responder -> requester
// Modports: slave (the responder), master (the CGRA side / stimulus).
// ---------------------------------------------------------------------------
interface cgra_mem_responder_if #(
   parameter int NPORTS = 4
);
   import cgra_config_pkg::*;

   logic [NPORTS-1:0]                          slave_data_req_i;
   logic [NPORTS-1:0]                          slave_data_gnt_o;
   logic [NPORTS-1:0]                          slave_data_rvalid_o;
   logic [NPORTS-1:0]                          slave_data_we_i;
   logic [NPORTS-1:0][BE_WIDTH-1:0]            slave_data_be_i;
   logic [NPORTS-1:0][DATA_BUS_ADD_WIDTH-1:0]  slave_data_addr_i;
   logic [NPORTS-1:0][DATA_BUS_DATA_WIDTH-1:0] slave_data_wdata_i;
   logic [NPORTS-1:0][DATA_BUS_DATA_WIDTH-1:0] slave_data_rdata_o;

   modport slave (
      input  slave_data_req_i, slave_data_we_i, slave_data_be_i,
             slave_data_addr_i, slave_data_wdata_i,
      output slave_data_gnt_o, slave_data_rvalid_o, slave_data_rdata_o
   );

   modport master (
      output slave_data_req_i, slave_data_we_i, slave_data_be_i,
             slave_data_addr_i, slave_data_wdata_i,
      input  slave_data_gnt_o, slave_data_rvalid_o, slave_data_rdata_o
   );

endinterface

// File: rtl/cgra_mem_resp_arbiter.sv
// ---------------------------------------------------------------------------
// cgra_mem_resp_arbiter
// Single-winner arbiter for the memory responder.
//   clk_i, rstn_i : clock / async active-low reset (round-robin build only)
//   req           : per-port request
//   gnt           : one-hot grant, combinational from req
//   gnt_idx       : index of the granted port (0 when nothing granted)
// Macro CGRA_MEM_RESP_RR_ARB_EN: when defined, round-robin starting at a
// pointer that moves to (last granted + 1) mod NPORTS; otherwise fixed
// priority with the lowest index winning and no state at all.
// ---------------------------------------------------------------------------
module cgra_mem_resp_arbiter #(
   parameter int NPORTS = 4,
   parameter int IDX_W  = 2
) (
`ifdef CGRA_MEM_RESP_RR_ARB_EN
   input  logic              clk_i,
   input  logic              rstn_i,
`endif
   input  logic [NPORTS-1:0] req,
   output logic [NPORTS-1:0] gnt,
   output logic [IDX_W-1:0]  gnt_idx
);

   logic             found;
   logic [IDX_W-1:0] cand;

`ifdef CGRA_MEM_RESP_RR_ARB_EN
   logic [IDX_W-1:0] ptr_reg;
   logic [IDX_W-1:0] ptr_next;

   // Scan every port once, starting at the pointer and wrapping around.
   always_comb begin
      gnt      = '0;
      gnt_idx  = '0;
      found    = 1'b0;
      cand     = '0;
      ptr_next = ptr_reg;
      for (int k = 0; k < NPORTS; k++) begin
         cand = IDX_W'((int'(ptr_reg) + k) % NPORTS);
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            gnt_idx   = cand;
         end
      end
      if (found) begin
         ptr_next = (int'(gnt_idx) == NPORTS - 1) ? '0 : gnt_idx + IDX_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         ptr_reg <= '0;
      end else begin
         ptr_reg <= ptr_next;
      end
   end
`else
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = '0;
      for (int k = 0; k < NPORTS; k++) begin
         cand = IDX_W'(k);
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            gnt_idx   = cand;
         end
      end
   end
`endif

endmodule

// File: rtl/cgra_mem_responder.sv
// ---------------------------------------------------------------------------
// cgra_mem_responder
// Shared single-ported word memory serving NPORTS CGRA requester ports.
// One access is granted per cycle; the response (rvalid + rdata) comes back
// on the granted port exactly LATENCY cycles after the grant edge.
//   clk_i  : clock
//   rstn_i : asynchronous active-low reset (memory contents are kept)
//   bus    : cgra_mem_responder_if.slave, all per-port request/response buses
// Parameters: NPORTS, MEM_WORDS (power of two), BASE_ADDR, LATENCY (1..4).
// Macro CGRA_MEM_RESP_RR_ARB_EN selects round-robin instead of fixed
// priority arbitration (see cgra_mem_resp_arbiter).
// ---------------------------------------------------------------------------
module cgra_mem_responder
   import cgra_config_pkg::*;
#(
   parameter int                          NPORTS    = 4,
   parameter int                          MEM_WORDS = 1024,
   parameter logic [DATA_BUS_ADD_WIDTH-1:0] BASE_ADDR = 32'h0,
   parameter int                          LATENCY   = 1
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   cgra_mem_responder_if.slave  bus
);

   localparam int IDX_W = idx_width(NPORTS);
   localparam int AW    = idx_width(MEM_WORDS);
   localparam int DW    = DATA_BUS_DATA_WIDTH;

   logic [NPORTS-1:0]             arb_gnt;
   logic [IDX_W-1:0]              arb_idx;
   logic [NPORTS-1:0]             gnt;
   logic                          acc_valid;
   logic                          acc_we;
   logic [BE_WIDTH-1:0]           acc_be;
   logic [DATA_BUS_ADD_WIDTH-1:0] acc_addr;
   logic [DW-1:0]                 acc_wdata;
   logic [DATA_BUS_ADD_WIDTH-1:0] word_off;
   logic                          in_range;
   logic [AW-1:0]                 word_idx;

   logic [DW-1:0] mem [MEM_WORDS];
   resp_entry_t   pipe_reg [LATENCY];
   resp_entry_t   out_entry;

   cgra_mem_resp_arbiter #(
      .NPORTS (NPORTS),
      .IDX_W  (IDX_W)
   ) u_arbiter (
`ifdef CGRA_MEM_RESP_RR_ARB_EN
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
`endif
      .req     (bus.slave_data_req_i),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx)
   );

   // No grants while reset is asserted, so nothing is accepted or written.
   assign gnt                  = arb_gnt & {NPORTS{rstn_i}};
   assign bus.slave_data_gnt_o = gnt;
   assign acc_valid            = |gnt;

   assign acc_we    = bus.slave_data_we_i[arb_idx];
   assign acc_be    = bus.slave_data_be_i[arb_idx];
   assign acc_addr  = bus.slave_data_addr_i[arb_idx];
   assign acc_wdata = bus.slave_data_wdata_i[arb_idx];

   // Addresses below BASE_ADDR wrap to a huge offset and land out of range.
   assign word_off = (acc_addr - BASE_ADDR) >> 2;
   assign in_range = word_off < DATA_BUS_ADD_WIDTH'(MEM_WORDS);
   assign word_idx = word_off[AW-1:0];

   // Byte-enabled write port; deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (acc_valid && acc_we && in_range) begin
         for (int b = 0; b < BE_WIDTH; b++) begin
            if (acc_be[b]) begin
               mem[word_idx][b*8 +: 8] <= acc_wdata[b*8 +: 8];
            end
         end
      end
   end

   // Stage 0 captures the word at the grant edge (registered read); the
   // remaining stages just delay it so a new grant can enter every cycle.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int s = 0; s < LATENCY; s++) begin
            pipe_reg[s] <= '0;
         end
      end else begin
         pipe_reg[0].valid <= acc_valid;
         pipe_reg[0].port  <= PORT_IDX_W'(arb_idx);
         pipe_reg[0].data  <= (acc_valid && !acc_we && in_range) ? mem[word_idx] : '0;
         for (int s = 1; s < LATENCY; s++) begin
            pipe_reg[s] <= pipe_reg[s-1];
         end
      end
   end

   assign out_entry = pipe_reg[LATENCY-1];

   // Per-port response: rdata follows the pipeline on the rvalid cycle and
   // otherwise shows the last value delivered to that port.
   generate
      for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
         logic          port_hit;
         logic [DW-1:0] rdata_reg;

         assign port_hit = out_entry.valid && (out_entry.port == PORT_IDX_W'(gi));

         always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
               rdata_reg <= '0;
            end else if (port_hit) begin
               rdata_reg <= out_entry.data;
            end
         end

         assign bus.slave_data_rvalid_o[gi] = port_hit;
         assign bus.slave_data_rdata_o[gi]  = port_hit ? out_entry.data : rdata_reg;
      end
   endgenerate

endmodule

// File: tb/tb_cgra_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_cgra_mem_responder
// Directed stimulus with hand-computed expectations. The driver checks the
// combinational grant and pushes the expected response into a scoreboard;
// a separate monitor pops and checks every rvalid (port, data, arrival cycle).
// ---------------------------------------------------------------------------
module tb_cgra_mem_responder;

   localparam int          NP   = 4;
   localparam int          MW   = 1024;
   localparam logic [31:0] BASE = 32'h1000_0000;
   localparam int          LAT  = 3;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   cyc  = 0;
   int   total = 0;
   int   bad   = 0;

   int          q_port [$];
   int          q_due  [$];
   logic [31:0] q_data [$];

   cgra_mem_responder_if #(.NPORTS(NP)) bus ();

   cgra_mem_responder #(
      .NPORTS    (NP),
      .MEM_WORDS (MW),
      .BASE_ADDR (BASE),
      .LATENCY   (LAT)
   ) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h required %h (cyc %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic logic [31:0] pre_val(input int i);
      return 32'hC0DE_0000 + 32'(i) * 32'h0000_0101;
   endfunction

   task automatic set_port(input logic [1:0] p, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
      bus.slave_data_we_i[p]    = we;
      bus.slave_data_be_i[p]    = be;
      bus.slave_data_addr_i[p]  = addr;
      bus.slave_data_wdata_i[p] = wdata;
   endtask

   // Called #1 after a rising edge; drives req for one cycle, checks gnt
   // mid-cycle and queues the expected response for the granted port.
   task automatic issue(input string tag, input logic [3:0] req_v,
                        input logic [3:0] exp_gnt, input logic [31:0] exp_rdata);
      bus.slave_data_req_i = req_v;
      @(negedge clk);
      check({tag, "_gnt"}, 32'(bus.slave_data_gnt_o), 32'(exp_gnt));
      for (int p = 0; p < NP; p++) begin
         if (exp_gnt[p]) begin
            $display("req %s port=%0d we=%0d addr=%h wdata=%h cyc=%0d", tag, p,
                     bus.slave_data_we_i[2'(p)], bus.slave_data_addr_i[2'(p)],
                     bus.slave_data_wdata_i[2'(p)], cyc);
            q_port.push_back(p);
            q_data.push_back(exp_rdata);
            q_due.push_back(cyc + LAT);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_gnt"}, 32'(bus.slave_data_gnt_o), 32'h0);
      check({tag, "_rvalid"}, 32'(bus.slave_data_rvalid_o), 32'h0);
      for (int p = 0; p < NP; p++) begin
         check({tag, "_rdata"}, bus.slave_data_rdata_o[2'(p)], 32'h0);
      end
   endtask

   // Monitor: every rvalid must match the head of the scoreboard.
   always @(negedge clk) begin
      for (int p = 0; p < NP; p++) begin
         if (bus.slave_data_rvalid_o[2'(p)]) begin
            $display("rsp port=%0d rdata=%h cyc=%0d", p, bus.slave_data_rdata_o[2'(p)], cyc);
            if (q_port.size() == 0) begin
               total++;
               bad++;
               $display("FAIL rsp_unexpected: rvalid on port %0d, required none (cyc %0d)", p, cyc);
            end else begin
               check("rsp_port", 32'(p), 32'(q_port.pop_front()));
               check("rsp_data", bus.slave_data_rdata_o[2'(p)], q_data.pop_front());
               check("rsp_cycle", 32'(cyc), 32'(q_due.pop_front()));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] exp_g;

      bus.slave_data_req_i   = '0;
      bus.slave_data_we_i    = '0;
      bus.slave_data_be_i    = '0;
      bus.slave_data_addr_i  = '0;
      bus.slave_data_wdata_i = '0;

      // Reset state with every port requesting: nothing may be granted.
      rstn = 1'b0;
      bus.slave_data_req_i = 4'hF;
      @(negedge clk);
      check_idle("reset0");
      @(posedge clk);
      #1;
      rstn = 1'b1;
      bus.slave_data_req_i = '0;

      // Preload words 8..15 through port 3.
      for (int i = 0; i < 8; i++) begin
         set_port(2'd3, 1'b1, 4'hF, BASE + 32'h20 + 32'(4 * i), pre_val(i));
         issue("pre_wr", 4'b1000, 4'b1000, 32'h0);
      end

      // Full-word write on port 0, read back on port 2.
      set_port(2'd0, 1'b1, 4'hF, BASE + 32'h10, 32'hDEAD_BEEF);
      issue("wr_dead", 4'b0001, 4'b0001, 32'h0);
      set_port(2'd2, 1'b0, 4'hF, BASE + 32'h10, 32'h0);
      issue("rd_dead", 4'b0100, 4'b0100, 32'hDEAD_BEEF);

      // Partial byte write, read immediately after.
      set_port(2'd1, 1'b1, 4'hF, BASE + 32'h14, 32'h1122_3344);
      issue("wr_full", 4'b0010, 4'b0010, 32'h0);
      set_port(2'd3, 1'b1, 4'b0010, BASE + 32'h14, 32'h0000_AB00);
      issue("wr_be", 4'b1000, 4'b1000, 32'h0);
      set_port(2'd0, 1'b0, 4'hF, BASE + 32'h14, 32'h0);
      issue("rd_be", 4'b0001, 4'b0001, 32'h1122_AB44);

      // Low address bits are ignored.
      set_port(2'd1, 1'b0, 4'h0, BASE + 32'h13, 32'h0);
      issue("rd_lowbits", 4'b0010, 4'b0010, 32'hDEAD_BEEF);

      // Out-of-range: first word past the end, a write that would alias
      // word 8 if truncated, an address below BASE, then word 8 unchanged.
      set_port(2'd2, 1'b0, 4'hF, BASE + 32'(MW * 4), 32'h0);
      issue("rd_oor", 4'b0100, 4'b0100, 32'h0);
      set_port(2'd2, 1'b1, 4'hF, BASE + 32'(MW * 4) + 32'h20, 32'hFFFF_FFFF);
      issue("wr_oor", 4'b0100, 4'b0100, 32'h0);
      set_port(2'd2, 1'b0, 4'hF, BASE - 32'h4, 32'h0);
      issue("rd_below", 4'b0100, 4'b0100, 32'h0);
      set_port(2'd3, 1'b0, 4'hF, BASE + 32'h20, 32'h0);
      issue("rd_alias", 4'b1000, 4'b1000, pre_val(0));

      // Back-to-back reads alternating ports 0/1: one response per cycle.
      for (int i = 0; i < 16; i++) begin
         set_port(2'(i % 2), 1'b0, 4'hF, BASE + 32'h20 + 32'(4 * (i % 8)), 32'h0);
         issue("b2b", 4'(1 << (i % 2)), 4'(1 << (i % 2)), pre_val(i % 8));
      end

      // Two reads in flight, then a one-cycle reset: both are dropped.
      set_port(2'd0, 1'b0, 4'hF, BASE + 32'h10, 32'h0);
      issue("rd_drop_a", 4'b0001, 4'b0001, 32'hDEAD_BEEF);
      set_port(2'd1, 1'b0, 4'hF, BASE + 32'h14, 32'h0);
      issue("rd_drop_b", 4'b0010, 4'b0010, 32'h1122_AB44);
      rstn = 1'b0;
      bus.slave_data_req_i = 4'hF;
      q_port.delete();
      q_data.delete();
      q_due.delete();
      @(negedge clk);
      check_idle("reset1");
      @(posedge clk);
      #1;
      rstn = 1'b1;

      // All ports read continuously starting in the first cycle after reset.
      for (int p = 0; p < NP; p++) begin
         set_port(2'(p), 1'b0, 4'hF, BASE + 32'h10, 32'h0);
      end
      for (int i = 0; i < 8; i++) begin
`ifdef CGRA_MEM_RESP_RR_ARB_EN
         exp_g = 4'(1 << (i % 4));
`else
         exp_g = 4'b0001;
`endif
         issue("rd_all", 4'hF, exp_g, 32'hDEAD_BEEF);
      end
      bus.slave_data_req_i = '0;

      // Drain and verify everything queued was delivered; rdata holds.
      repeat (LAT + 2) @(posedge clk);
      @(negedge clk);
      check("sb_drain", 32'(q_port.size()), 32'h0);
      check("rdata_hold", bus.slave_data_rdata_o[0], 32'hDEAD_BEEF);
      check("idle_rvalid", 32'(bus.slave_data_rvalid_o), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
